// File: rtl/io_scheduler_if.sv
// io_scheduler_if: controller byte port, UART byte engine link and FIFO status of the I/O scheduler.
interface io_scheduler_if #(parameter int RX_AW = 4, parameter int TX_AW = 4);
   logic              io_read_req;
   logic              io_write_req;
   logic [7:0]        io_wdata;
   logic              io_ready;
   logic              io_done;
   logic [7:0]        io_rdata;
   logic [7:0]        uart_tx_data;
   logic              uart_tx_valid;
   logic              uart_tx_ready;
   logic [7:0]        uart_rx_data;
   logic              uart_rx_valid;
   logic [RX_AW:0]    rx_count;
   logic [TX_AW:0]    tx_count;
   logic              rx_overrun;
   logic              proto_err;
   modport slave (
      input  io_read_req, io_write_req, io_wdata, uart_tx_ready, uart_rx_data, uart_rx_valid,
      output io_ready, io_done, io_rdata, uart_tx_data, uart_tx_valid, rx_count, tx_count,
      rx_overrun, proto_err
   );
   modport master (
      output io_read_req, io_write_req, io_wdata, uart_tx_ready, uart_rx_data, uart_rx_valid,
      input  io_ready, io_done, io_rdata, uart_tx_data, uart_tx_valid, rx_count, tx_count,
      rx_overrun, proto_err
   );
endinterface

// File: rtl/io_scheduler.sv
// io_scheduler: sequences controller byte reads/writes onto a UART byte engine through RX/TX FIFOs.
module io_scheduler #(
   parameter int RX_AW = 4,
   parameter int TX_AW = 4
) (
   input logic           CLK,
   input logic           RST,
   io_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, RD_REL} state_t;
   state_t           state, state_nxt;
   logic [7:0]       rx_mem [2**RX_AW];
   logic [7:0]       tx_mem [2**TX_AW];
   logic [RX_AW-1:0] rx_wp, rx_rp;
   logic [TX_AW-1:0] tx_wp, tx_rp;
   logic [RX_AW:0]   rx_cnt;
   logic [TX_AW:0]   tx_cnt;
   logic [7:0]       rdata;
   logic             rx_full, rx_empty, rx_push, rx_pop;
   logic             tx_full, tx_empty, tx_push, tx_pop;
   logic             overrun, perr, wr_bad;
   // Counts saturate at exactly 2^AW, so the MSB alone flags full.
   assign rx_full  = rx_cnt[RX_AW];
   assign tx_full  = tx_cnt[TX_AW];
   assign rx_empty = rx_cnt == '0;
   assign tx_empty = tx_cnt == '0;
   assign rx_pop   = !rx_empty && ((state == IDLE && bus.io_read_req) || state == RD_WAIT);
   assign rx_push  = bus.uart_rx_valid && (!rx_full || rx_pop);
   assign tx_pop   = !tx_empty && bus.uart_tx_ready;
   assign wr_bad   = bus.io_write_req && (state != IDLE || bus.io_read_req || tx_full);
   assign tx_push  = bus.io_write_req && state == IDLE && !bus.io_read_req && (!tx_full || tx_pop);
   assign bus.io_ready      = state == IDLE && !tx_full;
   assign bus.io_done       = state == RD_DONE;
   assign bus.io_rdata      = rdata;
   assign bus.uart_tx_valid = !tx_empty;
   assign bus.uart_tx_data  = tx_mem[tx_rp];
   assign bus.rx_count      = rx_cnt;
   assign bus.tx_count      = tx_cnt;
   assign bus.rx_overrun    = overrun;
   assign bus.proto_err     = perr;
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    state_nxt = bus.io_read_req ? (rx_empty ? RD_WAIT : RD_DONE) : IDLE;
         RD_WAIT: state_nxt = rx_empty ? RD_WAIT : RD_DONE;
         RD_DONE: state_nxt = RD_REL;
         RD_REL:  state_nxt = bus.io_read_req ? RD_REL : IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         rx_wp   <= '0;
         rx_rp   <= '0;
         rx_cnt  <= '0;
         tx_wp   <= '0;
         tx_rp   <= '0;
         tx_cnt  <= '0;
         rdata   <= '0;
         overrun <= 1'b0;
         perr    <= 1'b0;
      end else begin
         state  <= state_nxt;
         rx_wp  <= rx_wp + RX_AW'(rx_push);
         rx_rp  <= rx_rp + RX_AW'(rx_pop);
         rx_cnt <= rx_cnt + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
         tx_wp  <= tx_wp + TX_AW'(tx_push);
         tx_rp  <= tx_rp + TX_AW'(tx_pop);
         tx_cnt <= tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
         if (rx_pop) rdata <= rx_mem[rx_rp];
         if (bus.uart_rx_valid && !rx_push) overrun <= 1'b1;
         if (wr_bad) perr <= 1'b1;
      end
   end
   always_ff @(posedge CLK) begin
      if (rx_push) rx_mem[rx_wp] <= bus.uart_rx_data;
      if (tx_push) tx_mem[tx_wp] <= bus.io_wdata;
   end
endmodule

// File: tb/tb_io_scheduler.sv
// tb_io_scheduler: directed vectors with hand-computed expectations for io_scheduler.
module tb_io_scheduler;
   logic CLK, RST;
   int checks, failures;
   io_scheduler_if #(.RX_AW(4), .TX_AW(4)) bus ();
   io_scheduler #(.RX_AW(4), .TX_AW(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic do_reset();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask
   task automatic rx_byte(input logic [7:0] b);
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data  = b;
      step();
      bus.uart_rx_valid = 1'b0;
   endtask
   task automatic wr_byte(input logic [7:0] b);
      bus.io_write_req = 1'b1;
      bus.io_wdata     = b;
      step();
      bus.io_write_req = 1'b0;
   endtask
   task automatic do_read(input string tag, input logic [7:0] exp);
      bus.io_read_req = 1'b1;
      step();
      chk({tag, "_done"}, bus.io_done, 1);
      chk({tag, "_rdata"}, bus.io_rdata, exp);
      step();
      chk({tag, "_done_low"}, bus.io_done, 0);
      bus.io_read_req = 1'b0;
      step();
   endtask
   initial begin
      checks = 0;
      failures = 0;
      bus.io_read_req = 0;
      bus.io_write_req = 0;
      bus.io_wdata = 0;
      bus.uart_tx_ready = 0;
      bus.uart_rx_data = 0;
      bus.uart_rx_valid = 0;
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      chk("rst_ready", bus.io_ready, 1);
      chk("rst_done", bus.io_done, 0);
      chk("rst_rdata", bus.io_rdata, 0);
      chk("rst_rxcnt", bus.rx_count, 0);
      chk("rst_txcnt", bus.tx_count, 0);
      chk("rst_txvalid", bus.uart_tx_valid, 0);
      chk("rst_flags", {bus.rx_overrun, bus.proto_err}, 0);
      // Buffered reads
      rx_byte(8'h41);
      rx_byte(8'h42);
      chk("rx_cnt2", bus.rx_count, 2);
      do_read("rd41", 8'h41);
      chk("rx_cnt1", bus.rx_count, 1);
      do_read("rd42", 8'h42);
      chk("rx_cnt0", bus.rx_count, 0);
      // Read waiting on an empty FIFO
      bus.io_read_req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("wait_ready", bus.io_ready, 0);
         chk("wait_done", bus.io_done, 0);
      end
      rx_byte(8'h5A);
      chk("wait_t1_done", bus.io_done, 0);
      step();
      chk("wait_t2_done", bus.io_done, 1);
      chk("wait_rdata", bus.io_rdata, 8'h5A);
      step();
      chk("wait_done_low", bus.io_done, 0);
      chk("wait_rdata_hold", bus.io_rdata, 8'h5A);
      bus.io_read_req = 1'b0;
      step();
      chk("wait_back_idle", bus.io_ready, 1);
      // TX ordering and drain
      for (int i = 0; i < 4; i++) wr_byte(8'h10 + 8'(i));
      chk("tx_cnt4", bus.tx_count, 4);
      chk("tx_head", bus.uart_tx_data, 8'h10);
      chk("tx_valid", bus.uart_tx_valid, 1);
      bus.uart_tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("tx_drain", bus.uart_tx_data, 8'h10 + 8'(i));
         step();
      end
      chk("tx_empty_valid", bus.uart_tx_valid, 0);
      chk("tx_empty_cnt", bus.tx_count, 0);
      bus.uart_tx_ready = 1'b0;
      // TX full and write dropped
      for (int i = 0; i < 16; i++) wr_byte(8'hA0 + 8'(i));
      chk("txfull_cnt", bus.tx_count, 16);
      chk("txfull_ready", bus.io_ready, 0);
      chk("txfull_perr0", bus.proto_err, 0);
      wr_byte(8'hEE);
      chk("txfull_perr", bus.proto_err, 1);
      chk("txfull_cnt_hold", bus.tx_count, 16);
      chk("txfull_head", bus.uart_tx_data, 8'hA0);
      do_reset();
      chk("perr_clear", bus.proto_err, 0);
      // RX full: simultaneous push/pop, then overrun
      for (int i = 0; i < 16; i++) rx_byte(8'h80 + 8'(i));
      chk("rxfull_cnt", bus.rx_count, 16);
      bus.io_read_req = 1'b1;
      bus.uart_rx_valid = 1'b1;
      bus.uart_rx_data = 8'hEE;
      step();
      bus.uart_rx_valid = 1'b0;
      chk("rxpp_done", bus.io_done, 1);
      chk("rxpp_rdata", bus.io_rdata, 8'h80);
      chk("rxpp_cnt", bus.rx_count, 16);
      chk("rxpp_ovr", bus.rx_overrun, 0);
      step();
      bus.io_read_req = 1'b0;
      step();
      rx_byte(8'hFF);
      chk("ovr_flag", bus.rx_overrun, 1);
      chk("ovr_cnt", bus.rx_count, 16);
      for (int i = 1; i < 16; i++) do_read("rxorder", 8'h80 + 8'(i));
      do_read("rxlast", 8'hEE);
      chk("rx_drained", bus.rx_count, 0);
      chk("ovr_sticky", bus.rx_overrun, 1);
      // Reset in the middle of a waiting read
      do_reset();
      for (int i = 0; i < 3; i++) wr_byte(8'h30 + 8'(i));
      bus.io_read_req = 1'b1;
      step();
      chk("rdwait_ready", bus.io_ready, 0);
      wr_byte(8'h77);
      chk("rdwait_perr", bus.proto_err, 1);
      chk("rdwait_txcnt", bus.tx_count, 3);
      bus.io_read_req = 1'b0;
      do_reset();
      chk("mid_ready", bus.io_ready, 1);
      chk("mid_txcnt", bus.tx_count, 0);
      chk("mid_txvalid", bus.uart_tx_valid, 0);
      chk("mid_done", bus.io_done, 0);
      chk("mid_flags", {bus.rx_overrun, bus.proto_err}, 0);
      step();
      chk("mid_done_after", bus.io_done, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/io_scheduler.md
Name: io_scheduler

Overview:
- Sequences the CPU controller's byte I/O port (io_read_req / io_write_req / io_ready / io_done) onto a UART byte engine.
- Buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO, so the core never stalls on line timing except for a read with no data buffered.
- Sits between the controller and the UART TX/RX modules. It owns all I/O sequencing and flow control.

Parameters:
- RX_AW, 4, log2 of RX FIFO depth (16 entries)
- TX_AW, 4, log2 of TX FIFO depth (16 entries)

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST  in  1  synchronous active-high reset
- io_read_req  in  1  controller read request; held high until the cycle after io_done
- io_write_req  in  1  controller write request; one-cycle pulse, only issued while io_ready=1
- io_wdata  in  8  write byte, valid while io_write_req=1
- io_ready  out  1  scheduler can accept a new request
- io_done  out  1  one-cycle pulse; read data valid
- io_rdata  out  8  read byte
- uart_tx_data  out  8  byte to transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts byte when valid&ready
- uart_rx_data  in  8  received byte
- uart_rx_valid  in  1  one-cycle pulse per received byte
- rx_count  out  RX_AW+1  RX FIFO occupancy
- tx_count  out  TX_AW+1  TX FIFO occupancy
- rx_overrun  out  1  sticky: a byte was dropped because the RX FIFO was full
- proto_err  out  1  sticky: protocol violation detected

Behaviour:
- Reset, RST=1 at posedge:
  - state=IDLE; both FIFOs flushed (pointers and counts 0).
  - io_done=0, io_rdata=0, rx_overrun=0, proto_err=0.
  - uart_tx_valid=0 follows from the empty TX FIFO.
  - Reset mid-read abandons the transfer silently; no io_done is produced.
- States: IDLE, RD_WAIT, RD_DONE, RD_REL.
- io_ready (combinational) = (state==IDLE) && (tx_count < 2^TX_AW).
- IDLE:
  - If io_write_req: push io_wdata to TX FIFO. Stay IDLE.
  - If io_read_req and rx_count>0: pop RX head into io_rdata, go to RD_DONE.
  - If io_read_req and rx_count==0: go to RD_WAIT.
  - If io_read_req and io_write_req are high together: the read is serviced, the write is dropped, proto_err is set.
  - If io_write_req arrives while the TX FIFO is full: the write is dropped, proto_err is set.
- RD_WAIT: on the first cycle rx_count>0, pop into io_rdata and go to RD_DONE.
- RD_DONE: io_done=1 for exactly this cycle; go to RD_REL.
- RD_REL:
  - Stay while io_read_req=1; go to IDLE when it drops.
  - io_write_req seen in RD_WAIT/RD_DONE/RD_REL sets proto_err and is dropped.
- io_rdata holds its value from RD_DONE until the next pop.
- Read latency:
  - Data buffered, request sampled in IDLE at cycle t: io_done at t+1.
  - Byte arriving at cycle t while in RD_WAIT: written at t, popped at t+1, io_done at t+2. There is no bypass path.
- RX side:
  - uart_rx_valid pushes uart_rx_data.
  - Push and pop in the same cycle are both honoured; the count is unchanged, even when full.
  - Push to a full FIFO with no simultaneous pop: byte dropped, rx_overrun set.
- TX side:
  - uart_tx_valid = tx_count>0; uart_tx_data = TX head (combinational from FIFO memory).
  - Pop on uart_tx_valid & uart_tx_ready.
  - Push and pop in the same cycle: count unchanged. A push when full with a simultaneous pop is accepted, but io_ready is already 0 in that case, so such a push is a proto_err.
- FIFO pointers are AW bits and wrap modulo depth; counts are AW+1 bits and saturate at 2^AW by construction.
- rx_overrun and proto_err clear only on RST.
- Byte ordering is strictly FIFO on both paths.

Test Plan:
- Reset, then uart_rx_valid with 0x41 then 0x42; read twice → io_done one cycle after each request, io_rdata=0x41 then 0x42, rx_count 2→1→0.
- Read with an empty FIFO, hold 20 cycles, then uart_rx_valid 0x5A → io_done exactly 2 cycles after the rx pulse, io_rdata=0x5A, io_ready=0 throughout the wait.
- Four write pulses 0x10..0x13 with uart_tx_ready=0 → tx_count=4, uart_tx_data=0x10; set ready=1 → bytes drain 0x10,0x11,0x12,0x13 on consecutive cycles.
- Fill the TX FIFO with 16 bytes → io_ready=0; a 17th write pulse → proto_err=1, tx_count stays 16.
- Push 16 RX bytes, then a 17th with no pop → rx_overrun=1, rx_count=16, head still the first byte. A 17th push coincident with a pop → accepted, count stays 16, no overrun.
- Assert RST while in RD_WAIT with 3 bytes in the TX FIFO → next cycle state=IDLE, tx_count=0, uart_tx_valid=0, no io_done, sticky flags 0.
